// File: rtl/lsu_pkg.sv
// Shared types, funct3 codes and decode helpers for the load/store unit.
package lsu_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      LOAD_WAIT = 2'd1,
      RMW_MERGE = 2'd2,
      RMW_WRITE = 2'd3
   } lsu_state_t;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
      logic mis;
      case (funct3)
         F3_H, F3_HU: mis = addr_lo[0];
         F3_W:        mis = (addr_lo != 2'b00);
         default:     mis = 1'b0;
      endcase
      return mis;
   endfunction

   function automatic logic is_legal(input logic we, input logic [2:0] funct3);
      logic ok;
      if (we) ok = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W);
      else    ok = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W) ||
                   (funct3 == F3_BU) || (funct3 == F3_HU);
      return ok;
   endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational byte/half lane logic: load extraction with extension and
// store merge of a sub-word into an existing memory word.
module lsu_align
   import lsu_pkg::*;
#(
   parameter int unsigned XLEN = 32
) (
   input  logic [XLEN-1:0] mem_rdata,
   input  logic [2:0]      funct3,
   input  logic [1:0]      offset,
   input  logic [XLEN-1:0] new_data,
   output logic [XLEN-1:0] load_data,
   output logic [XLEN-1:0] merged
);

   logic [XLEN-1:0] shifted;
   logic [7:0]      sel_b;
   logic [15:0]     sel_h;

   always_comb begin
      shifted = mem_rdata >> {offset, 3'b000};
      sel_b   = shifted[7:0];
      sel_h   = shifted[15:0];
      case (funct3)
         F3_B:    load_data = {{(XLEN-8){sel_b[7]}}, sel_b};
         F3_H:    load_data = {{(XLEN-16){sel_h[15]}}, sel_h};
         F3_W:    load_data = mem_rdata;
         F3_BU:   load_data = {{(XLEN-8){1'b0}}, sel_b};
         F3_HU:   load_data = {{(XLEN-16){1'b0}}, sel_h};
         default: load_data = '0;
      endcase
   end

   always_comb begin
      merged = mem_rdata;
      case (funct3)
         F3_B:    merged[{offset, 3'b000} +: 8]     = new_data[7:0];
         F3_H:    merged[{offset[1], 4'b0000} +: 16] = new_data[15:0];
         default: merged = new_data;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit in front of a word-wide synchronous SRAM without
// byte enables; sub-word stores are done by read-modify-write.
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int unsigned MEM_AW = 8,
   parameter int unsigned XLEN   = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [2:0]        req_funct3,
   input  logic [XLEN-1:0]   req_addr,
   input  logic [XLEN-1:0]   req_wdata,
   output logic              rsp_valid,
   output logic [XLEN-1:0]   rsp_rdata,
   output logic              rsp_fault,
   output logic              mem_en,
   output logic              mem_we,
   output logic [MEM_AW-1:0] mem_addr,
   output logic [XLEN-1:0]   mem_wdata,
   input  logic [XLEN-1:0]   mem_rdata
);

   lsu_state_t        state_q, state_d;
   logic [MEM_AW-1:0] addr_q, addr_d;
   logic [1:0]        off_q, off_d;
   logic [2:0]        f3_q, f3_d;
   logic [XLEN-1:0]   wdata_q, wdata_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic              rsp_fault_q, rsp_fault_d;
   logic [XLEN-1:0]   rsp_rdata_q, rsp_rdata_d;

   logic              accept;
   logic              fault;
   logic [XLEN-1:0]   load_data;
   logic [XLEN-1:0]   merged;
   logic              unused_addr_hi;

   assign unused_addr_hi = ^req_addr[XLEN-1:MEM_AW+2];

   lsu_align #(.XLEN(XLEN)) u_align (
      .mem_rdata (mem_rdata),
      .funct3    (f3_q),
      .offset    (off_q),
      .new_data  (wdata_q),
      .load_data (load_data),
      .merged    (merged)
   );

   assign req_ready = (state_q == IDLE) && reset;
   assign accept    = req_valid && req_ready;
   assign fault     = !is_legal(req_we, req_funct3) || is_misaligned(req_funct3, req_addr[1:0]);

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      off_d       = off_q;
      f3_d        = f3_q;
      wdata_d     = wdata_q;
      rsp_valid_d = 1'b0;
      rsp_fault_d = 1'b0;
      rsp_rdata_d = '0;
      mem_en      = 1'b0;
      mem_we      = 1'b0;
      mem_addr    = addr_q;
      mem_wdata   = wdata_q;
      case (state_q)
         IDLE: begin
            // The SRAM is strobed in the accept cycle, so the address comes straight from the request.
            mem_addr = req_addr[MEM_AW+1:2];
            if (accept) begin
               addr_d  = req_addr[MEM_AW+1:2];
               off_d   = req_addr[1:0];
               f3_d    = req_funct3;
               wdata_d = req_wdata;
               if (fault) begin
                  rsp_valid_d = 1'b1;
                  rsp_fault_d = 1'b1;
               end else if (req_we && (req_funct3 == F3_W)) begin
                  mem_en      = 1'b1;
                  mem_we      = 1'b1;
                  mem_wdata   = req_wdata;
                  rsp_valid_d = 1'b1;
               end else if (req_we) begin
                  mem_en  = 1'b1;
                  state_d = RMW_MERGE;
               end else begin
                  mem_en  = 1'b1;
                  state_d = LOAD_WAIT;
               end
            end
         end
         LOAD_WAIT: begin
            rsp_rdata_d = load_data;
            rsp_valid_d = 1'b1;
            state_d     = IDLE;
         end
         RMW_MERGE: begin
            // Store data register is reused to hold the merged word for the write.
            wdata_d = merged;
            state_d = RMW_WRITE;
         end
         RMW_WRITE: begin
            mem_en      = 1'b1;
            mem_we      = 1'b1;
            rsp_valid_d = 1'b1;
            state_d     = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         addr_q      <= '0;
         off_q       <= '0;
         f3_q        <= '0;
         wdata_q     <= '0;
         rsp_valid_q <= 1'b0;
         rsp_fault_q <= 1'b0;
         rsp_rdata_q <= '0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         off_q       <= off_d;
         f3_q        <= f3_d;
         wdata_q     <= wdata_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_fault_q <= rsp_fault_d;
         rsp_rdata_q <= rsp_rdata_d;
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_fault = rsp_fault_q;
   assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit with a behavioural SRAM.
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [2:0]  req_funct3 = 3'b000;
   logic [31:0] req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_fault;
   logic        mem_en;
   logic        mem_we;
   logic [7:0]  mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata = '0;

   logic [31:0] mem [256] = '{24: 32'h876543A1, default: 32'h0};
   int unsigned wr_cnt = 0;

   int checks = 0;
   int errors = 0;

   load_store_unit #(.MEM_AW(8), .XLEN(32)) dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_funct3 (req_funct3),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .rsp_valid  (rsp_valid),
      .rsp_rdata  (rsp_rdata),
      .rsp_fault  (rsp_fault),
      .mem_en     (mem_en),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
            wr_cnt        <= wr_cnt + 1;
         end
         mem_rdata <= mem[mem_addr];
      end
   end

   typedef struct {
      string       name;
      logic        we;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
      logic        exp_fault;
      int          exp_lat;
      logic        exp_en;
      logic [31:0] exp_word;
   } vec_t;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   task automatic wait_accept(input string nm);
      int n;
      n = 0;
      @(negedge clk);
      while (!req_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk({nm, "_accept"}, {31'b0, req_ready}, 32'd1);
   endtask

   task automatic run_vec(input vec_t v, output logic [31:0] rd, output logic flt,
                          output int lat, output logic en_seen, output logic ready_early,
                          output logic pulse2);
      req_we     = v.we;
      req_funct3 = v.f3;
      req_addr   = v.addr;
      req_wdata  = v.wdata;
      req_valid  = 1'b1;
      wait_accept(v.name);
      en_seen = mem_en;
      @(posedge clk);
      #1 req_valid = 1'b0;
      lat = 0;
      rd = '0;
      flt = 1'b0;
      ready_early = 1'b0;
      for (int c = 1; c <= 10; c++) begin
         @(negedge clk);
         en_seen = en_seen | mem_en;
         if (rsp_valid) begin
            lat = c;
            rd  = rsp_rdata;
            flt = rsp_fault;
            break;
         end
         ready_early = ready_early | req_ready;
      end
      @(negedge clk);
      pulse2 = rsp_valid;
      @(posedge clk);
      #1;
   endtask

   vec_t vecs[19];

   initial begin
      #200000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

   initial begin
      logic [31:0] rd;
      logic        flt, en, rdy, p2;
      int          lat;
      int unsigned wc;

      vecs[0]  = '{"lw_60",     1'b0, 3'b010, 32'h60,  32'h0,        32'h876543A1, 1'b0, 2, 1'b1, 32'h876543A1};
      vecs[1]  = '{"lb_60",     1'b0, 3'b000, 32'h60,  32'h0,        32'hFFFFFFA1, 1'b0, 2, 1'b1, 32'h876543A1};
      vecs[2]  = '{"lbu_63",    1'b0, 3'b100, 32'h63,  32'h0,        32'h00000087, 1'b0, 2, 1'b1, 32'h876543A1};
      vecs[3]  = '{"lh_62",     1'b0, 3'b001, 32'h62,  32'h0,        32'hFFFF8765, 1'b0, 2, 1'b1, 32'h876543A1};
      vecs[4]  = '{"lhu_62",    1'b0, 3'b101, 32'h62,  32'h0,        32'h00008765, 1'b0, 2, 1'b1, 32'h876543A1};
      vecs[5]  = '{"sb_61",     1'b1, 3'b000, 32'h61,  32'h000000FF, 32'h0,        1'b0, 3, 1'b1, 32'h8765FFA1};
      vecs[6]  = '{"lw_60b",    1'b0, 3'b010, 32'h60,  32'h0,        32'h8765FFA1, 1'b0, 2, 1'b1, 32'h8765FFA1};
      vecs[7]  = '{"lw_62_mis", 1'b0, 3'b010, 32'h62,  32'h0,        32'h0,        1'b1, 1, 1'b0, 32'h8765FFA1};
      vecs[8]  = '{"ld_f3_011", 1'b0, 3'b011, 32'h60,  32'h0,        32'h0,        1'b1, 1, 1'b0, 32'h8765FFA1};
      vecs[9]  = '{"sh_63_mis", 1'b1, 3'b001, 32'h63,  32'h0000BEEF, 32'h0,        1'b1, 1, 1'b0, 32'h8765FFA1};
      vecs[10] = '{"st_f3_100", 1'b1, 3'b100, 32'h60,  32'hDEADBEEF, 32'h0,        1'b1, 1, 1'b0, 32'h8765FFA1};
      vecs[11] = '{"sh_62",     1'b1, 3'b001, 32'h62,  32'h1234ABCD, 32'h0,        1'b0, 3, 1'b1, 32'hABCDFFA1};
      vecs[12] = '{"lw_60c",    1'b0, 3'b010, 32'h60,  32'h0,        32'hABCDFFA1, 1'b0, 2, 1'b1, 32'hABCDFFA1};
      vecs[13] = '{"lh_61_mis", 1'b0, 3'b001, 32'h61,  32'h0,        32'h0,        1'b1, 1, 1'b0, 32'hABCDFFA1};
      vecs[14] = '{"lhu_60",    1'b0, 3'b101, 32'h60,  32'h0,        32'h0000FFA1, 1'b0, 2, 1'b1, 32'hABCDFFA1};
      vecs[15] = '{"lb_61",     1'b0, 3'b000, 32'h61,  32'h0,        32'hFFFFFFFF, 1'b0, 2, 1'b1, 32'hABCDFFA1};
      vecs[16] = '{"lw_wrap",   1'b0, 3'b010, 32'h460, 32'h0,        32'hABCDFFA1, 1'b0, 2, 1'b1, 32'hABCDFFA1};
      vecs[17] = '{"lh_62b",    1'b0, 3'b001, 32'h62,  32'h0,        32'hFFFFABCD, 1'b0, 2, 1'b1, 32'hABCDFFA1};
      vecs[18] = '{"lbu_62",    1'b0, 3'b100, 32'h62,  32'h0,        32'h000000CD, 1'b0, 2, 1'b1, 32'hABCDFFA1};

      // reset state
      repeat (2) @(negedge clk);
      chk("rst_req_ready", {31'b0, req_ready}, 32'd0);
      chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
      chk("rst_rsp_fault", {31'b0, rsp_fault}, 32'd0);
      chk("rst_rsp_rdata", rsp_rdata, 32'd0);
      chk("rst_mem_en",    {31'b0, mem_en},    32'd0);
      @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk);
      #1;

      for (int i = 0; i < 19; i++) begin
         run_vec(vecs[i], rd, flt, lat, en, rdy, p2);
         chk({vecs[i].name, "_rdata"}, rd, vecs[i].exp_rdata);
         chk({vecs[i].name, "_fault"}, {31'b0, flt}, {31'b0, vecs[i].exp_fault});
         chk({vecs[i].name, "_latency"}, lat, vecs[i].exp_lat);
         chk({vecs[i].name, "_mem_en"}, {31'b0, en}, {31'b0, vecs[i].exp_en});
         chk({vecs[i].name, "_ready_busy"}, {31'b0, rdy}, 32'd0);
         chk({vecs[i].name, "_pulse"}, {31'b0, p2}, 32'd0);
         chk({vecs[i].name, "_word18"}, mem[8'h18], vecs[i].exp_word);
      end

      // reset asserted while an sh sits in RMW_MERGE
      wc = wr_cnt;
      req_we = 1'b1; req_funct3 = 3'b001; req_addr = 32'h62; req_wdata = 32'h00005555;
      req_valid = 1'b1;
      wait_accept("rst_sh");
      @(posedge clk);
      #1 req_valid = 1'b0;
      reset = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk("rstmid_mem_we", {31'b0, mem_we}, 32'd0);
         chk("rstmid_mem_en", {31'b0, mem_en}, 32'd0);
         chk("rstmid_rsp_valid", {31'b0, rsp_valid}, 32'd0);
         chk("rstmid_req_ready", {31'b0, req_ready}, 32'd0);
      end
      chk("rstmid_rsp_rdata", rsp_rdata, 32'd0);
      chk("rstmid_rsp_fault", {31'b0, rsp_fault}, 32'd0);
      @(posedge clk);
      #1 reset = 1'b1;
      @(negedge clk);
      chk("rstmid_no_write", wr_cnt, wc);
      chk("rstmid_word18", mem[8'h18], 32'hABCDFFA1);
      @(posedge clk);
      #1;
      run_vec('{"sw_64", 1'b1, 3'b010, 32'h64, 32'd25, 32'h0, 1'b0, 1, 1'b1, 32'h0}, rd, flt, lat, en, rdy, p2);
      chk("sw_64_latency", lat, 1);
      chk("sw_64_fault", {31'b0, flt}, 32'd0);
      chk("sw_64_word19", mem[8'h19], 32'h00000019);

      // back-to-back: second accept coincides with first response
      req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h60; req_valid = 1'b1;
      wait_accept("b2b_first");
      @(posedge clk);
      #1 req_funct3 = 3'b100;
      @(negedge clk);
      chk("b2b_t1_rsp_valid", {31'b0, rsp_valid}, 32'd0);
      chk("b2b_t1_req_ready", {31'b0, req_ready}, 32'd0);
      @(negedge clk);
      chk("b2b_t2_rsp_valid", {31'b0, rsp_valid}, 32'd1);
      chk("b2b_t2_rdata", rsp_rdata, 32'hABCDFFA1);
      chk("b2b_t2_req_ready", {31'b0, req_ready}, 32'd1);
      chk("b2b_t2_mem_en", {31'b0, mem_en}, 32'd1);
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      chk("b2b_t3_rsp_valid", {31'b0, rsp_valid}, 32'd0);
      @(negedge clk);
      chk("b2b_t4_rsp_valid", {31'b0, rsp_valid}, 32'd1);
      chk("b2b_t4_rdata", rsp_rdata, 32'h000000A1);
      chk("b2b_t4_fault", {31'b0, rsp_fault}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
